// File: rtl/tx_byte_sequencer_if.sv
// Descriptor, TX-queue word and byte-stream channels of the TX byte sequencer.
// slave is the sequencer's view; master is the surrounding controller/queue/target.
interface tx_byte_sequencer_if #(
  parameter int DataWidth = 32,
  parameter int LenWidth  = 16
);
  logic                 desc_valid_i;
  logic                 desc_ready_o;
  logic [LenWidth-1:0]  desc_len_i;
  logic                 data_valid_i;
  logic                 data_ready_o;
  logic [DataWidth-1:0] data_i;
  logic                 byte_valid_o;
  logic                 byte_ready_i;
  logic [7:0]           byte_o;
  logic                 byte_last_o;

  modport slave (
    input  desc_valid_i, desc_len_i, data_valid_i, data_i, byte_ready_i,
    output desc_ready_o, data_ready_o, byte_valid_o, byte_o, byte_last_o
  );

  modport master (
    output desc_valid_i, desc_len_i, data_valid_i, data_i, byte_ready_i,
    input  desc_ready_o, data_ready_o, byte_valid_o, byte_o, byte_last_o
  );
endinterface

// File: rtl/tx_byte_sequencer.sv
// Serialises TX queue words into a little-endian byte stream for a descriptor-given length.
// One fetch cycle per word, then one byte per accepted cycle; byte_ready_i stalls hold the byte stable.
module tx_byte_sequencer #(
  parameter int DataWidth = 32,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tx_byte_sequencer_if.slave   bus,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o
);

  localparam int Bytes     = DataWidth / 8;
  localparam int BcntWidth = $clog2(Bytes + 1);
  localparam logic [LenWidth-1:0]  BytesLen = LenWidth'(Bytes);
  localparam logic [BcntWidth-1:0] BytesCnt = BcntWidth'(Bytes);
  localparam logic [LenWidth-1:0]  OneLen   = LenWidth'(1);
  localparam logic [BcntWidth-1:0] OneCnt   = BcntWidth'(1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StSend  = 2'd2,
    StDrain = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [LenWidth-1:0]  remaining_q, remaining_d;
  logic [LenWidth-1:0]  words_left_q, words_left_d;
  logic [BcntWidth-1:0] bcnt_q, bcnt_d;
  logic [DataWidth-1:0] sreg_q, sreg_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  logic                desc_hs, data_hs, byte_hs;
  logic [LenWidth-1:0] words_calc;
  logic [LenWidth-1:0] words_after_pop;

  assign bus.desc_ready_o = (state_q == StIdle);
  assign bus.data_ready_o = (state_q == StFetch) || (state_q == StDrain);
  assign bus.byte_valid_o = (state_q == StSend);
  assign bus.byte_o       = sreg_q[7:0];
  assign bus.byte_last_o  = (state_q == StSend) && (remaining_q == OneLen);
  assign busy_o           = (state_q != StIdle);
  assign done_o           = done_q;
  assign aborted_o        = aborted_q;

  assign desc_hs = bus.desc_valid_i && bus.desc_ready_o;
  assign data_hs = bus.data_valid_i && bus.data_ready_o;
  assign byte_hs = bus.byte_valid_o && bus.byte_ready_i;

  // Word count rounds up so a partial final word is still popped.
  assign words_calc = (bus.desc_len_i / BytesLen)
                    + {{(LenWidth-1){1'b0}}, |(bus.desc_len_i % BytesLen)};
  assign words_after_pop = data_hs ? (words_left_q - OneLen) : words_left_q;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    words_left_d = words_left_q;
    bcnt_d       = bcnt_q;
    sreg_d       = sreg_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (desc_hs) begin
          if (bus.desc_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d  = bus.desc_len_i;
            words_left_d = words_calc;
            state_d      = StFetch;
          end
        end
      end

      StFetch: begin
        if (abort_i) begin
          // A word popped in the abort cycle is consumed and dropped.
          remaining_d  = '0;
          bcnt_d       = '0;
          words_left_d = words_after_pop;
          if (words_after_pop != '0) begin
            state_d = StDrain;
          end else begin
            state_d   = StIdle;
            aborted_d = 1'b1;
          end
        end else if (data_hs) begin
          sreg_d       = bus.data_i;
          bcnt_d       = (remaining_q >= BytesLen) ? BytesCnt : BcntWidth'(remaining_q);
          words_left_d = words_left_q - OneLen;
          state_d      = StSend;
        end
      end

      StSend: begin
        if (byte_hs) begin
          sreg_d      = sreg_q >> 8;
          remaining_d = remaining_q - OneLen;
          bcnt_d      = bcnt_q - OneCnt;
        end
        // Delivering the final byte wins over a coincident abort.
        if (byte_hs && (remaining_q == OneLen)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (abort_i) begin
          remaining_d = '0;
          bcnt_d      = '0;
          if (words_left_q != '0) begin
            state_d = StDrain;
          end else begin
            state_d   = StIdle;
            aborted_d = 1'b1;
          end
        end else if (byte_hs && (bcnt_q == OneCnt)) begin
          state_d = StFetch;
        end
      end

      StDrain: begin
        if (data_hs) begin
          words_left_d = words_left_q - OneLen;
          if (words_left_q == OneLen) begin
            state_d   = StIdle;
            aborted_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      words_left_q <= '0;
      bcnt_q       <= '0;
      sreg_q       <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      words_left_q <= words_left_d;
      bcnt_q       <= bcnt_d;
      sreg_q       <= sreg_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

endmodule

// File: doc/tx_byte_sequencer.md
TX_BYTE_SEQUENCER -- requirements
Module: tx_byte_sequencer

Interface
REQ-001 SHALL have parameter DataWidth, default 32, TX data word width; a multiple of 8 and at least 16.
REQ-002 SHALL have parameter LenWidth, default 16, width of the descriptor byte-length field.
REQ-003 SHALL have ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- desc_valid_i  in  1  descriptor valid.
- desc_ready_o  out  1  descriptor ready.
- desc_len_i  in  LenWidth  transfer length in bytes.
- data_valid_i  in  1  TX queue word valid.
- data_ready_o  out  1  TX queue word pop.
- data_i  in  DataWidth  TX queue word.
- byte_valid_o  out  1  byte to target FSM valid.
- byte_ready_i  in  1  target FSM accepts byte.
- byte_o  out  8  byte data.
- byte_last_o  out  1  final byte of transfer.
- abort_i  in  1  controller ended read early; level, sampled each cycle.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse: transfer completed normally.
- aborted_o  out  1  one-cycle pulse: abort fully drained.

Function
REQ-004 SHALL use Bytes = DataWidth/8 and transfer Words = ceil(len/Bytes).
REQ-005 SHALL hold registers: remaining (LenWidth bits, bytes left), words_left (LenWidth bits, unpopped words), bcnt (valid bytes in the shift register), sreg (DataWidth bits).
REQ-006 SHALL implement FSM states IDLE, FETCH, SEND and DRAIN.
REQ-007 SHALL assert desc_ready_o only in IDLE.
REQ-008 SHALL assert data_ready_o only in FETCH and DRAIN.
REQ-009 SHALL assert byte_valid_o only in SEND.
REQ-010 IDLE, descriptor handshake with len=0: SHALL pulse done_o next cycle and stay IDLE.
REQ-011 IDLE, descriptor handshake with len>0: SHALL load remaining=len and words_left=Words, then go to FETCH.
REQ-012 FETCH, data handshake: SHALL set sreg=data_i, bcnt=min(Bytes,remaining), decrement words_left, then go to SEND.
REQ-013 SEND: SHALL drive byte_o=sreg[7:0], i.e. little-endian (byte 0 = data_i[7:0]).
REQ-014 SEND: SHALL drive byte_last_o = (remaining==1); it is combinational and qualified by byte_valid_o.
REQ-015 SEND, byte handshake: SHALL shift sreg right 8, and decrement remaining and bcnt.
REQ-016 After the REQ-015 decrement, if remaining reaches 0 the block SHALL go to IDLE and pulse done_o next cycle; else if bcnt reaches 0 it SHALL go to FETCH.
REQ-017 Padding bytes in the final word (the upper Bytes - (len mod Bytes) bytes, when nonzero) SHALL be discarded and never presented.
REQ-018 byte_o and byte_last_o SHALL stay stable while byte_valid_o=1 and byte_ready_i=0.
REQ-019 abort_i in FETCH or SEND: SHALL clear remaining and bcnt; go to DRAIN if words_left != 0 after any same-cycle pop, else go to IDLE and pulse aborted_o.
REQ-020 Abort in FETCH with a same-cycle data handshake: the word SHALL count as popped and be discarded.
REQ-021 Abort with a same-cycle byte handshake on the last byte: the transfer SHALL complete normally (done_o pulses, abort ignored).
REQ-022 Abort with a same-cycle byte handshake on a non-last byte: the byte SHALL count as delivered, then REQ-019 applies.
REQ-023 abort_i SHALL be ignored in IDLE and DRAIN.
REQ-024 DRAIN: SHALL pop and discard words, decrementing words_left on each handshake; when it reaches 0, go to IDLE and pulse aborted_o next cycle.
REQ-025 done_o and aborted_o SHALL be registered, never high in the same cycle, and never high for more than one cycle per transfer.
REQ-026 A new descriptor SHALL NOT be accepted before the done_o/aborted_o cycle; the earliest desc_ready_o is that same cycle.

Reset
REQ-027 While rst_ni=0: state=IDLE and all registers zero.
REQ-028 While rst_ni=0: outputs desc_ready_o=1, data_ready_o=0, byte_valid_o=0, byte_o=0, byte_last_o=0, busy_o=0, done_o=0, aborted_o=0.
REQ-029 Reset mid-transfer SHALL discard all state; no queue words are popped after reset.

Verification
REQ-030 len=4, word 0x44332211, byte_ready_i=1 -> bytes 11,22,33,44; last on 44; one pop; done_o once.
REQ-031 len=6, words 0x44332211 then 0x88776655 -> bytes 11..66; last on 66; 77/88 never output; two pops.
REQ-032 len=0 -> no pops, no bytes, done_o one cycle after handshake.
REQ-033 len=12, abort_i after 2 bytes accepted -> aborted_o pulse; exactly 3 words popped total; no further bytes.
REQ-034 len=5, byte_ready_i toggling 1/0, data_valid_i gaps -> byte_o stable while stalled; order 5 bytes correct.
REQ-035 len=8, rst_ni low after 3 bytes, then new desc len=1 with word 0xAA -> single byte AA, last=1, done_o.
